// File: rtl/viterbi_tbu_pp_if.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_tbu_pp_if
// Description : Handshake bundle between the ACS/SDS units, the ping-pong
//               trace-back unit and the descrambler.
//               master : environment side (drives decisions, start state,
//                        accepts decoded bits)
//               slave  : trace-back unit side
// Signals     : di_sur_path/di_sur_path_vld/di_rdy   decision vector input
//               di_start_state/di_start_vld          trace-back start state
//               do_sur/do_vld/do_rdy/do_last         decoded bit stream
//               do_ovf                               dropped-vector flag,
//                                                    only with TBU_OVF_FLAG_EN
// Revision    : 1.0 - initial release
// ============================================================================
interface viterbi_tbu_pp_if #(
    parameter int NUM_STATES = 64
) ();
    localparam int STATE_W = $clog2(NUM_STATES);

    logic [NUM_STATES-1:0] di_sur_path;
    logic                  di_sur_path_vld;
    logic                  di_rdy;
    logic [STATE_W-1:0]    di_start_state;
    logic                  di_start_vld;
    logic                  do_sur;
    logic                  do_vld;
    logic                  do_rdy;
    logic                  do_last;
`ifdef TBU_OVF_FLAG_EN
    logic                  do_ovf;

    modport master (
        output di_sur_path, di_sur_path_vld, di_start_state, di_start_vld, do_rdy,
        input  di_rdy, do_sur, do_vld, do_last, do_ovf
    );
    modport slave (
        input  di_sur_path, di_sur_path_vld, di_start_state, di_start_vld, do_rdy,
        output di_rdy, do_sur, do_vld, do_last, do_ovf
    );
`else
    modport master (
        output di_sur_path, di_sur_path_vld, di_start_state, di_start_vld, do_rdy,
        input  di_rdy, do_sur, do_vld, do_last
    );
    modport slave (
        input  di_sur_path, di_sur_path_vld, di_start_state, di_start_vld, do_rdy,
        output di_rdy, do_sur, do_vld, do_last
    );
`endif
endinterface
`default_nettype wire

// File: rtl/viterbi_tbu_pp.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_tbu_pp
// Description : Ping-pong trace-back unit. Decision vectors are written per
//               frame into one of two banks; the oldest full bank is traced
//               back from the start state given by the SDS unit while the
//               other bank fills. Decoded bits are reversed into time order
//               through a LIFO, tail bits are dropped, and the frame is sent
//               out over a valid/ready handshake.
// Ports       : clk    working clock
//               rst_n  asynchronous reset, active low
//               bus    viterbi_tbu_pp_if.slave (decision input, start state,
//                      decoded bit output)
// Options     : TBU_OVF_FLAG_EN - adds sticky bus.do_ovf, set the cycle after
//               a decision vector is offered while di_rdy is low.
// Revision    : 1.0 - initial release
// ============================================================================
module viterbi_tbu_pp #(
    parameter int NUM_STATES = 64,
    parameter int FRAME_LEN  = 32,
    parameter int TAIL_LEN   = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    viterbi_tbu_pp_if.slave bus
);
    localparam int STATE_W = $clog2(NUM_STATES);
    localparam int OUT_LEN = FRAME_LEN - TAIL_LEN;
    localparam int COL_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int IDX_W   = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(FRAME_LEN - 1);
    localparam logic [COL_W-1:0] OUT_COLS = COL_W'(OUT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_TRACE  = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    // Survivor RAM: two banks, one decision vector per trellis column
    logic [NUM_STATES-1:0] mem_q [2][FRAME_LEN];
    logic [NUM_STATES-1:0] rd_data_q;
    logic [COL_W-1:0]      rd_col;

    // Write side
    logic [COL_W-1:0] wr_col_q, wr_col_d;
    logic             wr_bank_q, wr_bank_d;
    logic [1:0]       full_q, full_d;
    logic             oldest_q, oldest_d;
    logic             wr_fire;
    logic             rel_bank;

    // Trace / output side
    state_t               state_q, state_d;
    logic [STATE_W-1:0]   tb_st_q, tb_st_d;
    logic [COL_W-1:0]     tb_col_q, tb_col_d;
    logic [OUT_LEN-1:0]   lifo_q, lifo_d;
    logic [IDX_W-1:0]     out_idx_q, out_idx_d;
    logic [IDX_W-1:0]     out_idx_nxt;
    logic                 do_sur_q, do_sur_d;
    logic                 do_vld_q, do_vld_d;
    logic                 do_last_q, do_last_d;

    assign bus.di_rdy  = ~full_q[wr_bank_q];
    assign wr_fire     = bus.di_sur_path_vld & ~full_q[wr_bank_q];
    assign rel_bank    = (state_q == S_TRACE) && (tb_col_q == '0);
    assign out_idx_nxt = out_idx_q + 1'b1;

    assign bus.do_sur  = do_sur_q;
    assign bus.do_vld  = do_vld_q;
    assign bus.do_last = do_last_q;

    // RAM: no reset, synchronous read of the bank under trace
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_col_q] <= bus.di_sur_path;
        end
        rd_data_q <= mem_q[oldest_q][rd_col];
    end

    // Write-side bookkeeping; a full-mark and a release always hit different
    // banks (only a non-full bank is written, only a full bank is traced).
    always_comb begin
        wr_col_d  = wr_col_q;
        wr_bank_d = wr_bank_q;
        full_d    = full_q;
        oldest_d  = oldest_q;
        if (wr_fire) begin
            if (wr_col_q == LAST_COL) begin
                wr_col_d          = '0;
                wr_bank_d         = ~wr_bank_q;
                full_d[wr_bank_q] = 1'b1;
            end else begin
                wr_col_d = wr_col_q + 1'b1;
            end
        end
        if (rel_bank) begin
            full_d[oldest_q] = 1'b0;
            oldest_d         = ~oldest_q;
        end
    end

    // Trace-back FSM and output stage
    always_comb begin
        state_d   = state_q;
        tb_st_d   = tb_st_q;
        tb_col_d  = tb_col_q;
        rd_col    = tb_col_q;
        lifo_d    = lifo_q;
        out_idx_d = out_idx_q;
        do_sur_d  = do_sur_q;
        do_vld_d  = do_vld_q;
        do_last_d = do_last_q;
        case (state_q)
            S_IDLE: begin
                if (bus.di_start_vld && full_q[oldest_q]) begin
                    tb_st_d = bus.di_start_state;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rd_col   = LAST_COL;
                tb_col_d = LAST_COL;
                state_d  = S_TRACE;
            end
            S_TRACE: begin
                // rd_data_q holds column tb_col_q; prefetch the next one down
                rd_col   = tb_col_q - 1'b1;
                tb_col_d = tb_col_q - 1'b1;
                if (tb_col_q < OUT_COLS) begin
                    lifo_d[tb_col_q] = tb_st_q[0];
                end
                // Undo the shift: the survivor bit is the MSB the shift dropped
                tb_st_d = {rd_data_q[tb_st_q], tb_st_q[STATE_W-1:1]};
                if (tb_col_q == '0) begin
                    out_idx_d = '0;
                    state_d   = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (!do_vld_q) begin
                    do_vld_d  = 1'b1;
                    do_sur_d  = lifo_q[out_idx_q];
                    do_last_d = (out_idx_q == LAST_IDX);
                end else if (bus.do_rdy) begin
                    if (do_last_q) begin
                        do_vld_d  = 1'b0;
                        do_sur_d  = 1'b0;
                        do_last_d = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        out_idx_d = out_idx_nxt;
                        do_sur_d  = lifo_q[out_idx_nxt];
                        do_last_d = (out_idx_nxt == LAST_IDX);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_col_q  <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
            oldest_q  <= 1'b0;
            state_q   <= S_IDLE;
            tb_st_q   <= '0;
            tb_col_q  <= '0;
            lifo_q    <= '0;
            out_idx_q <= '0;
            do_sur_q  <= 1'b0;
            do_vld_q  <= 1'b0;
            do_last_q <= 1'b0;
        end else begin
            wr_col_q  <= wr_col_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            oldest_q  <= oldest_d;
            state_q   <= state_d;
            tb_st_q   <= tb_st_d;
            tb_col_q  <= tb_col_d;
            lifo_q    <= lifo_d;
            out_idx_q <= out_idx_d;
            do_sur_q  <= do_sur_d;
            do_vld_q  <= do_vld_d;
            do_last_q <= do_last_d;
        end
    end

`ifdef TBU_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    assign ovf_d      = ovf_q | (bus.di_sur_path_vld & full_q[wr_bank_q]);
    assign bus.do_ovf = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule
`default_nettype wire
